gs_ddram_bridge: RTL and testbench

- Byte-wide memory port for the General Sound (GS) sample RAM, 2 MB space (21-bit byte address), backed by the DDR3 64-bit Avalon-style interface.
- Sits between the tsconf core's GS memory bus and the top-level DDRAM_* pins.
- Holds a one-word (64-bit) read cache, so consecutive byte reads within the same 8-byte word skip the DDR3 latency.

---
 rtl/gs_ddram_bridge.sv | 140 ++++++++++++++
 tb/tb_gs_ddram_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_ddram_bridge.sv
// gs_ddram_bridge: byte-wide General Sound sample RAM port onto the 64-bit
// DDR3 Avalon-style interface. A single 64-bit word is cached so that byte
// reads falling in the most recently fetched word skip the DDR3 round trip.
// Writes always go through to DDR3 and patch the cached word when it matches.
module gs_ddram_bridge #(
  parameter logic [3:0] BASE = 4'b0011
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [2:0] {IDLE, HIT, RDCMD, RDWAIT, WRCMD} state_t;

  state_t      state;
  logic        rd_p0;
  logic        we_p0;
  logic [17:0] word_p1;
  logic [2:0]  lane_p1;
  logic [63:0] cache_data;
  logic [17:0] cache_tag;
  logic        cache_vld;

  logic        rd_edge;
  logic        we_edge;
  logic        hit;
  logic        wr_start;
  logic        rd_start;

  // Byte lane extraction, lane 0 is bits 7:0.
  function automatic logic [7:0] lane_sel(input logic [63:0] w, input logic [2:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction

  assign rd_edge  = rd & ~rd_p0;
  assign we_edge  = we & ~we_p0;
  assign hit      = cache_vld && (cache_tag == addr[20:3]);
  // A write edge takes priority; a simultaneous read edge is dropped.
  assign wr_start = (state == IDLE) && we_edge;
  assign rd_start = (state == IDLE) && rd_edge && !we_edge;

  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = {BASE, 7'b0, word_p1};

  // Request lines keep tracking every cycle so edges during a transaction are lost, not queued.
  always_ff @(posedge DDRAM_CLK) begin
    rd_p0 <= rd;
    we_p0 <= we;
  end

  // Request latch, write data lanes and cache word/tag storage.
  always_ff @(posedge DDRAM_CLK) begin
    if (wr_start || rd_start) begin
      word_p1 <= addr[20:3];
      lane_p1 <= addr[2:0];
    end
    if (wr_start) begin
      DDRAM_DIN <= {8{din}};
      DDRAM_BE  <= 8'b1 << addr[2:0];
      if (hit)
        cache_data[{addr[2:0], 3'b000} +: 8] <= din;
    end
    if (state == RDWAIT && DDRAM_DOUT_READY) begin
      cache_data <= DDRAM_DOUT;
      cache_tag  <= word_p1;
    end
  end

  // Transaction FSM with registered handshake, strobe and read-data outputs.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      dout      <= 8'd0;
      DDRAM_RD  <= 1'b0;
      DDRAM_WE  <= 1'b0;
      cache_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_start) begin
            ready    <= 1'b0;
            DDRAM_WE <= 1'b1;
            state    <= WRCMD;
          end else if (rd_start) begin
            ready <= 1'b0;
            if (hit) begin
              state <= HIT;
            end else begin
              DDRAM_RD <= 1'b1;
              state    <= RDCMD;
            end
          end
        end
        HIT: begin
          dout  <= lane_sel(cache_data, lane_p1);
          ready <= 1'b1;
          state <= IDLE;
        end
        RDCMD: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (DDRAM_DOUT_READY) begin
            dout      <= lane_sel(DDRAM_DOUT, lane_p1);
            cache_vld <= 1'b1;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        WRCMD: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Self-checking bench for gs_ddram_bridge: a DDR3 responder with variable
// latency and BUSY, plus a byte-addressed reference memory and a one-word
// cache expectation used to predict read data and DDR3 traffic.
module tb_gs_ddram_bridge;

  localparam logic [3:0] BASE = 4'b0011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic        ready;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  gs_ddram_bridge #(.BASE(BASE)) dut (
    .DDRAM_CLK(clk), .reset(reset), .addr(addr), .din(din), .dout(dout),
    .rd(rd), .we(we), .ready(ready), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ticks = 0, t_start = 0, data_tick = 0;
  int rsp_cnt = 0, lat = 3, busy_hold = 0;
  bit rand_busy = 1'b0;
  logic [17:0] rsp_word;
  int rd_cmds = 0, wr_cmds = 0, rd_hi = 0, we_hi = 0;
  logic [28:0] rd_addr, wr_addr;
  logic [7:0]  wr_be;
  logic [63:0] wr_din;
  logic [63:0] mem [logic [17:0]];
  logic [7:0]  refm [logic [20:0]];
  bit          cache_ok = 1'b0;
  logic [17:0] cache_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [17:0] w);
    return {32'(w) * 32'h9E3779B1, 32'(w) ^ 32'h5A5AA5A5};
  endfunction

  function automatic logic [63:0] ddr_word(input logic [17:0] w);
    return mem.exists(w) ? mem[w] : init_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [20:0] a);
    logic [63:0] v;
    if (refm.exists(a)) return refm[a];
    v = init_word(a[20:3]);
    return v[{a[2:0], 3'b000} +: 8];
  endfunction

  // One clock: drive DDR-side inputs for the coming edge, record accepted commands.
  task automatic tick();
    bit deliver;
    logic [63:0] v;
    deliver = 1'b0;
    if (busy_hold > 0) begin
      DDRAM_BUSY = 1'b1;
      busy_hold--;
    end else begin
      DDRAM_BUSY = rand_busy ? ($urandom_range(0, 9) < 3) : 1'b0;
    end
    if (rsp_cnt == 1) begin
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT = ddr_word(rsp_word);
      rsp_cnt = 0;
      deliver = 1'b1;
    end else begin
      DDRAM_DOUT_READY = 1'b0;
      DDRAM_DOUT = {$urandom, $urandom};
      if (rsp_cnt > 1) rsp_cnt--;
    end
    if (DDRAM_RD && !DDRAM_BUSY) begin
      rd_cmds++;
      rd_addr  = DDRAM_ADDR;
      rsp_word = DDRAM_ADDR[17:0];
      rsp_cnt  = lat;
    end
    if (DDRAM_WE && !DDRAM_BUSY) begin
      wr_cmds++;
      wr_addr = DDRAM_ADDR;
      wr_be   = DDRAM_BE;
      wr_din  = DDRAM_DIN;
      v = ddr_word(DDRAM_ADDR[17:0]);
      for (int i = 0; i < 8; i++)
        if (DDRAM_BE[i]) v[i*8 +: 8] = DDRAM_DIN[i*8 +: 8];
      mem[DDRAM_ADDR[17:0]] = v;
    end
    @(posedge clk);
    @(negedge clk);
    ticks++;
    if (deliver) data_tick = ticks;
    if (DDRAM_RD) rd_hi++;
    if (DDRAM_WE) we_hi++;
  endtask

  // Raise the request lines for one cycle, then wait for ready counting low cycles.
  task automatic xact(input bit do_rd, input bit do_wr, input logic [20:0] a,
                      input logic [7:0] d, output int low);
    int n;
    rd_hi = 0; we_hi = 0; t_start = ticks;
    addr = a; din = d; rd = do_rd; we = do_wr;
    tick();
    rd = 1'b0; we = 1'b0;
    addr = 21'($urandom); din = 8'($urandom);
    low = 0; n = 0;
    while (!ready && n < 60) begin
      low++; n++;
      tick();
    end
    if (n >= 60) chk("ready_timeout", ready, 1);
  endtask

  task automatic rd_op(input logic [20:0] a, output int low);
    bit h;
    int rc;
    h  = cache_ok && (cache_w == a[20:3]);
    rc = rd_cmds;
    xact(1'b1, 1'b0, a, 8'($urandom), low);
    chk("rd_dout", dout, ref_byte(a));
    chk("rd_cmds", rd_cmds - rc, h ? 0 : 1);
    if (h) chk("hit_low", low, 1);
    else   chk("miss_addr", rd_addr, {BASE, 7'b0, a[20:3]});
    cache_ok = 1'b1;
    cache_w  = a[20:3];
  endtask

  task automatic wr_op(input logic [20:0] a, input logic [7:0] d, output int low);
    int wc;
    wc = wr_cmds;
    xact(1'b0, 1'b1, a, d, low);
    chk("wr_cmds", wr_cmds - wc, 1);
    chk("wr_addr", wr_addr, {BASE, 7'b0, a[20:3]});
    chk("wr_be", wr_be, 8'b1 << a[2:0]);
    chk("wr_din", wr_din, {8{d}});
    refm[a] = d;
  endtask

  initial begin
    int low, rc, wc;
    logic [63:0] pre;
    logic [17:0] pool [4];
    logic [20:0] a;

    @(negedge clk);
    repeat (3) tick();
    chk("rst_ready", ready, 1);
    chk("rst_dout", dout, 0);
    chk("rst_rd", DDRAM_RD, 0);
    chk("rst_we", DDRAM_WE, 0);
    chk("burstcnt", DDRAM_BURSTCNT, 1);
    reset = 1'b0;
    tick();

    pre = 64'h8877665544332211;
    mem[18'd0] = pre;
    for (int i = 0; i < 8; i++) refm[21'(i)] = pre[i*8 +: 8];

    // Miss at 0x000005, data three cycles after the command is taken.
    lat = 3;
    rd_op(21'h000005, low);
    chk("miss_dout", dout, 8'h66);
    chk("miss_rd_cycles", rd_hi, 1);
    chk("miss_ddr_addr", rd_addr, 29'h06000000);
    chk("miss_ready_low", low, data_tick - t_start - 1);

    // Same word: hit.
    rc = rd_cmds;
    rd_op(21'h000002, low);
    chk("hit_dout", dout, 8'h33);
    chk("hit_no_rd", rd_cmds - rc, 0);

    // Write at the top of the space with BUSY held for three command cycles.
    busy_hold = 4;
    wr_op(21'h1FFFFF, 8'hAB, low);
    chk("wr_we_cycles", we_hi, 4);
    chk("wr_ready_low", low, 4);
    chk("wr_top_addr", wr_addr, 29'h0603FFFF);
    chk("wr_top_be", wr_be, 8'h80);

    // Write into the cached word, then read it back from the cache.
    wr_op(21'h000001, 8'h5A, low);
    chk("wr_ready_low1", low, 1);
    rc = rd_cmds;
    rd_op(21'h000001, low);
    chk("coh_dout", dout, 8'h5A);
    chk("coh_no_rd", rd_cmds - rc, 0);

    // Simultaneous rd/we edges: only the write happens.
    rc = rd_cmds; wc = wr_cmds;
    xact(1'b1, 1'b1, 21'h000010, 8'hC3, low);
    chk("both_wr", wr_cmds - wc, 1);
    chk("both_no_rd", rd_cmds - rc, 0);
    chk("both_be", wr_be, 8'h01);
    chk("both_addr", wr_addr, 29'h06000002);
    refm[21'h000010] = 8'hC3;
    rd_op(21'h000003, low);
    chk("both_cache_kept", dout, 8'h44);

    // Reset while waiting for read data; the late DOUT_READY must be ignored.
    lat = 6;
    addr = 21'h000040; rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("abort_ready", ready, 1);
    chk("abort_dout", dout, 0);
    chk("abort_rd", DDRAM_RD, 0);
    cache_ok = 1'b0;
    lat = 3;
    rd_op(21'h000040, low);

    // Randomized mix over a small pool of words so hits and misses both occur.
    rand_busy = 1'b1;
    pool[0] = 18'd8;
    for (int i = 1; i < 4; i++) pool[i] = 18'($urandom);
    for (int it = 0; it < 200; it++) begin
      lat = $urandom_range(1, 5);
      a = {pool[$urandom_range(0, 3)], 3'($urandom)};
      if ($urandom_range(0, 2) == 2) wr_op(a, 8'($urandom), low);
      else rd_op(a, low);
    end
    rand_busy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
